// File: rtl/gi2c_mini_nes_poll.sv
// Poll scheduler, watchdog and button debouncer wrapped around the mini NES I2C reader.
// Issues periodic read requests, debounces the 9 button lines and publishes press/release events.
module gi2c_mini_nes_poll #(
    parameter int POLL_TICKS     = 400000,
    parameter int TIMEOUT_TICKS  = 200000,
    parameter int STABLE_SAMPLES = 2
) (
    input  logic       clk_40,
    input  logic       rst,
    input  logic       enable,
    output logic       request_data,
    input  logic       busy,
    input  logic       data_valid,
    input  logic [8:0] btn_raw,
    output logic [8:0] btn_state,
    output logic [8:0] btn_pressed,
    output logic [8:0] btn_released,
    output logic       update,
    output logic       timeout_err,
    output logic [1:0] dbg_state_o
);

    // Reader handshake: request_data is a single-cycle strobe issued only while busy=0;
    // the reader answers with a single-cycle data_valid, and btn_raw is valid in that same cycle.
    // data_valid outside a pending transaction carries no meaning and is dropped.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    localparam int TW = $clog2(POLL_TICKS + 1);
    localparam int WW = $clog2(TIMEOUT_TICKS + 1);
    localparam int MW = $clog2(STABLE_SAMPLES + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_TICKS - 1);
    localparam logic [WW-1:0] WDOG_FIRE  = WW'(TIMEOUT_TICKS - 2);
    localparam logic [MW-1:0] MATCH_FULL = MW'(STABLE_SAMPLES);
    localparam logic [8:0]    BTN_RESET  = 9'h100;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic [MW-1:0]   match_q, match_d;
    logic [8:0]      cand_q, cand_d;
    logic [8:0]      btn_state_q, btn_state_d;
    logic [8:0]      pressed_q, pressed_d;
    logic [8:0]      released_q, released_d;
    logic            update_q, update_d;
    logic            timeout_q, timeout_d;
    logic            pending_q, pending_d;

    logic            tick;
    logic            capture;
    logic [MW-1:0]   match_nx;
    logic [8:0]      cand_nx;

    assign tick = enable && (timer_q == '0);

    always_ff @(posedge clk_40) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            wdog_q      <= '0;
            match_q     <= '0;
            cand_q      <= BTN_RESET;
            btn_state_q <= BTN_RESET;
            pressed_q   <= '0;
            released_q  <= '0;
            update_q    <= 1'b0;
            timeout_q   <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            wdog_q      <= wdog_d;
            match_q     <= match_d;
            cand_q      <= cand_d;
            btn_state_q <= btn_state_d;
            pressed_q   <= pressed_d;
            released_q  <= released_d;
            update_q    <= update_d;
            timeout_q   <= timeout_d;
            pending_q   <= pending_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wdog_d      = wdog_q;
        match_d     = match_q;
        cand_d      = cand_q;
        btn_state_d = btn_state_q;
        pressed_d   = '0;
        released_d  = '0;
        update_d    = 1'b0;
        timeout_d   = timeout_q;
        pending_d   = pending_q;
        capture     = 1'b0;
        match_nx    = match_q;
        cand_nx     = cand_q;

        if (!enable) begin
            timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        // Ticks seen outside IDLE are simply lost; only a busy reader defers one.
        case (state_q)
            S_IDLE: begin
                if ((tick || (pending_q && enable)) && !busy) begin
                    state_d = S_REQ;
                end else if (tick && busy) begin
                    pending_d = 1'b1;
                end
            end
            S_REQ: begin
                pending_d = 1'b0;
                wdog_d    = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (data_valid) begin
                    capture = 1'b1;
                    state_d = S_IDLE;
                end else if (wdog_q == WDOG_FIRE) begin
                    wdog_d    = wdog_q + WW'(1);
                    timeout_d = 1'b1;
                    match_d   = '0;
                    state_d   = S_IDLE;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Debounce: a value must repeat on consecutive captures before it is published.
        if (capture) begin
            timeout_d = 1'b0;
            if (btn_raw == cand_q) begin
                cand_nx  = cand_q;
                match_nx = (match_q == MATCH_FULL) ? match_q : match_q + MW'(1);
            end else begin
                cand_nx  = btn_raw;
                match_nx = MW'(1);
            end
            cand_d  = cand_nx;
            match_d = match_nx;
            if ((match_nx == MATCH_FULL) && (cand_nx != btn_state_q)) begin
                btn_state_d = cand_nx;
                pressed_d   = cand_nx & ~btn_state_q;
                released_d  = ~cand_nx & btn_state_q;
                update_d    = 1'b1;
            end
        end
    end

    // Pulses are masked while rst is high so nothing leaks out of an aborted cycle.
    assign request_data = (state_q == S_REQ) && !rst;
    assign btn_state    = btn_state_q;
    assign btn_pressed  = rst ? '0 : pressed_q;
    assign btn_released = rst ? '0 : released_q;
    assign update       = update_q && !rst;
    assign timeout_err  = timeout_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_gi2c_mini_nes_poll.sv
// Directed bench for gi2c_mini_nes_poll: behavioural reader, update-event scoreboard,
// and cycle-accurate checks on request timing, watchdog and reset.
module tb_gi2c_mini_nes_poll;

    localparam int POLL = 20;
    localparam int TMO  = 50;
    localparam int STAB = 2;
    localparam int W    = 27;

    logic       clk_40 = 1'b0;
    logic       rst;
    logic       enable;
    logic [8:0] btn_raw;
    logic       request_data;
    logic [8:0] btn_state;
    logic [8:0] btn_pressed;
    logic [8:0] btn_released;
    logic       update;
    logic       timeout_err;
    logic [1:0] dbg_state_o;

    logic mdl_busy = 1'b0;
    logic mdl_dv   = 1'b0;
    logic frc_busy = 1'b0;
    logic spur_dv  = 1'b0;
    logic dv_en    = 1'b1;
    wire  busy       = mdl_busy | frc_busy;
    wire  data_valid = mdl_dv | spur_dv;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_on   = 1'b0;

    logic [W-1:0] exp_q[$];

    gi2c_mini_nes_poll #(
        .POLL_TICKS    (POLL),
        .TIMEOUT_TICKS (TMO),
        .STABLE_SAMPLES(STAB)
    ) dut (
        .clk_40      (clk_40),
        .rst         (rst),
        .enable      (enable),
        .request_data(request_data),
        .busy        (busy),
        .data_valid  (data_valid),
        .btn_raw     (btn_raw),
        .btn_state   (btn_state),
        .btn_pressed (btn_pressed),
        .btn_released(btn_released),
        .update      (update),
        .timeout_err (timeout_err),
        .dbg_state_o (dbg_state_o)
    );

    // Clock and cycle counter
    always #5 clk_40 = ~clk_40;
    always @(posedge clk_40) cyc = cyc + 1;

    // Reader model: busy for 3 cycles, data_valid 5 cycles after the request cycle
    int rd_age = 0;
    bit rd_act = 1'b0;
    always @(negedge clk_40) begin
        if (request_data === 1'b1) begin
            rd_act = 1'b1;
            rd_age = 0;
        end else if (rd_act) begin
            rd_age = rd_age + 1;
        end
        mdl_busy = rd_act && (rd_age >= 1) && (rd_age <= 3);
        mdl_dv   = rd_act && dv_en && (rd_age == 5);
        if (rd_act && rd_age >= 5) rd_act = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every update pulse must match the oldest expected event
    always @(negedge clk_40) begin
        logic [W-1:0] e;
        if (mon_on) begin
            if (update === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_update: state=0x%0h pressed=0x%0h released=0x%0h expected none (cycle %0d)",
                             btn_state, btn_pressed, btn_released, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("update_event", {5'd0, btn_state, btn_pressed, btn_released}, {5'd0, e});
                end
            end else begin
                check("no_pulse", {14'd0, btn_pressed, btn_released}, 32'd0);
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_request_data"}, {31'd0, request_data}, 32'd0);
        check({tag, "_btn_state"}, {23'd0, btn_state}, 32'h100);
        check({tag, "_btn_pressed"}, {23'd0, btn_pressed}, 32'd0);
        check({tag, "_btn_released"}, {23'd0, btn_released}, 32'd0);
        check({tag, "_update"}, {31'd0, update}, 32'd0);
        check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
        check({tag, "_fsm_idle"}, {30'd0, dbg_state_o}, 32'd0);
    endtask

    task automatic wait_req(output int c);
        c = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_40);
            if (request_data === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            checks++;
            failures++;
            $display("FAIL req_wait: no request_data within 100 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic poll(input logic [8:0] v, output int c);
        btn_raw = v;
        wait_req(c);
        repeat (6) @(negedge clk_40);
    endtask

    initial begin
        int e_cyc, c1, c2, c3, c, r, r2, t, drop;
        rst     = 1'b1;
        enable  = 1'b0;
        btn_raw = 9'h100;
        repeat (3) @(negedge clk_40);
        rst = 1'b0;
        @(negedge clk_40);
        check_reset("rst0");
        mon_on = 1'b1;

        // 1: first request follows enable immediately, then every POLL cycles
        enable = 1'b1;
        e_cyc  = cyc;
        poll(9'h100, c1);
        check("first_req_cycle", c1, e_cyc + 1);
        poll(9'h100, c2);
        check("poll_period_1", c2, c1 + POLL);
        poll(9'h100, c3);
        check("poll_period_2", c3, c2 + POLL);
        check("state_after_idle_polls", {23'd0, btn_state}, 32'h100);

        // 2: A pressed for two polls; event after the second
        poll(9'h004, c);
        check("state_after_one_A", {23'd0, btn_state}, 32'h100);
        exp_q.push_back({9'h004, 9'h004, 9'h100});
        poll(9'h004, c);
        check("state_after_two_A", {23'd0, btn_state}, 32'h004);

        // 3: alternating reads never settle
        poll(9'h100, c);
        poll(9'h004, c);
        poll(9'h100, c);
        poll(9'h004, c);
        check("state_after_alternate", {23'd0, btn_state}, 32'h004);
        poll(9'h001, c);

        // 4: watchdog, match count cleared, re-poll on next tick, clear on capture
        dv_en   = 1'b0;
        btn_raw = 9'h001;
        wait_req(r);
        t = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_40);
            if (timeout_err === 1'b1) begin
                t = cyc;
                break;
            end
        end
        check("timeout_cycle", t, r + TMO);
        dv_en = 1'b1;
        wait_req(r2);
        check("repoll_after_timeout", r2, r + 3 * POLL);
        repeat (5) @(negedge clk_40);
        check("timeout_held_until_capture", {31'd0, timeout_err}, 32'd1);
        @(negedge clk_40);
        check("timeout_cleared_by_capture", {31'd0, timeout_err}, 32'd0);
        check("state_after_timeout_repoll", {23'd0, btn_state}, 32'h004);
        exp_q.push_back({9'h001, 9'h001, 9'h004});
        poll(9'h001, c);
        check("state_after_start", {23'd0, btn_state}, 32'h001);

        // 5: busy across a tick defers the request until busy drops
        frc_busy = 1'b1;
        drop     = c + 24;
        while (cyc < drop) begin
            @(negedge clk_40);
            check("req_withheld_busy", {31'd0, request_data}, 32'd0);
        end
        frc_busy = 1'b0;
        wait_req(r);
        check("req_after_busy_drop", r, drop + 1);
        repeat (6) @(negedge clk_40);
        btn_raw = 9'h010;
        spur_dv = 1'b1;
        repeat (2) @(negedge clk_40);
        spur_dv = 1'b0;
        repeat (2) @(negedge clk_40);
        check("state_after_spurious_dv", {23'd0, btn_state}, 32'h001);
        check("fsm_idle_after_spurious", {30'd0, dbg_state_o}, 32'd0);

        // 6: reset during WAIT aborts; late data_valid ignored
        poll(9'h004, c);
        btn_raw = 9'h004;
        wait_req(r);
        repeat (2) @(negedge clk_40);
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk_40);
        check_reset("rst_wait");
        rst = 1'b0;
        repeat (5) @(negedge clk_40);
        check("state_after_late_dv", {23'd0, btn_state}, 32'h100);
        check("fsm_idle_after_late_dv", {30'd0, dbg_state_o}, 32'd0);
        check("timeout_after_late_dv", {31'd0, timeout_err}, 32'd0);

        repeat (2) @(negedge clk_40);
        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
